// File: rtl/sga_render_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sga_render_engine_if: control-unit <-> renderer handshake bundle.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sga_render_engine_if #(
    parameter int GRID_W = 3,
    parameter int SIZE_W = 5
);
    logic                  render_clr;
    logic                  render_step;
    logic [SIZE_W-1:0]     snake_size;
    logic [SIZE_W-1:0]     seg_addr;
    logic [2*GRID_W-1:0]   seg_pos;
    logic [2*GRID_W-1:0]   apple_pos;
    logic                  render_finish;

    modport master (
        output render_clr, render_step, snake_size, seg_pos, apple_pos,
        input  seg_addr, render_finish
    );

    modport slave (
        input  render_clr, render_step, snake_size, seg_pos, apple_pos,
        output seg_addr, render_finish
    );
endinterface
`default_nettype wire

// File: rtl/sga_render_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sga_render_engine: step-driven double-buffered snake frame renderer  |
// | with continuous row scan onto the LED matrix.          Rev 1.0       |
// +----------------------------------------------------------------------+
module sga_render_engine #(
    parameter int GRID_W   = 3,
    parameter int SIZE_W   = 5,
    parameter int MAX_SIZE = 16,
    parameter int SCAN_DIV = 1000
) (
    input  wire logic                     clock,
    input  wire logic                     restart,
    sga_render_engine_if.slave            rif,
    output logic [(1<<GRID_W)-1:0]        row_sel,
    output logic [(1<<GRID_W)-1:0]        col_data,
    output logic [7:0]                    db_frames
);
    localparam int ROWS = 1 << GRID_W;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]  C_DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [SIZE_W-1:0] C_MAX_SIZE = SIZE_W'(MAX_SIZE);

    logic [SIZE_W-1:0]         idx_q, idx_d;
    logic                      fin_q, fin_d;
    logic [7:0]                frames_q, frames_d;
    logic [ROWS-1:0][ROWS-1:0] back_q, back_d;
    logic [ROWS-1:0][ROWS-1:0] front_q, front_d;
    logic [DIV_W-1:0]          div_q;
    logic [GRID_W-1:0]         row_q;

    logic [SIZE_W-1:0] w_n;
    logic [GRID_W-1:0] w_seg_x, w_seg_y, w_app_x, w_app_y;

    assign w_n     = (rif.snake_size > C_MAX_SIZE) ? C_MAX_SIZE : rif.snake_size;
    assign w_seg_x = rif.seg_pos[2*GRID_W-1:GRID_W];
    assign w_seg_y = rif.seg_pos[GRID_W-1:0];
    assign w_app_x = rif.apple_pos[2*GRID_W-1:GRID_W];
    assign w_app_y = rif.apple_pos[GRID_W-1:0];

    // Step handling: acknowledge, draw one segment, or publish the frame.
    always_comb begin
        idx_d    = idx_q;
        fin_d    = fin_q;
        frames_d = frames_q;
        back_d   = back_q;
        front_d  = front_q;
        if (rif.render_clr) begin
            idx_d    = '0;
            fin_d    = 1'b0;
            frames_d = '0;
            back_d   = '0;
            front_d  = '0;
        end else if (rif.render_step) begin
            if (fin_q) begin
                fin_d = 1'b0;
                idx_d = '0;
            end else if (idx_q < w_n) begin
                back_d[w_seg_y][w_seg_x] = 1'b1;
                idx_d = idx_q + SIZE_W'(1);
            end else begin
                front_d = back_q;
                front_d[w_app_y][w_app_x] = 1'b1;
                back_d   = '0;
                fin_d    = 1'b1;
                frames_d = frames_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (restart) begin
            idx_q    <= '0;
            fin_q    <= 1'b0;
            frames_q <= '0;
            back_q   <= '0;
            front_q  <= '0;
        end else begin
            idx_q    <= idx_d;
            fin_q    <= fin_d;
            frames_q <= frames_d;
            back_q   <= back_d;
            front_q  <= front_d;
        end
    end

    // Row scan runs independently of the render handshake.
    always_ff @(posedge clock) begin
        if (restart) begin
            div_q <= '0;
            row_q <= '0;
        end else if (div_q == C_DIV_LAST) begin
            div_q <= '0;
            row_q <= row_q + GRID_W'(1);
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign rif.seg_addr      = idx_q;
    assign rif.render_finish = fin_q;
    assign db_frames         = frames_q;
    assign row_sel           = ROWS'(1) << row_q;
    assign col_data          = front_q[row_q];
endmodule
`default_nettype wire

// File: tb/tb_sga_render_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sga_render_engine: directed self-checking bench for the renderer. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sga_render_engine;
    logic       clk;
    logic       rst;
    logic [7:0] row_sel;
    logic [7:0] col_data;
    logic [7:0] db_frames;
    logic [5:0] body_mem [32];
    int         n_assert;
    int         n_fail;

    sga_render_engine_if #(.GRID_W(3), .SIZE_W(5)) rif ();

    sga_render_engine #(
        .GRID_W(3), .SIZE_W(5), .MAX_SIZE(16), .SCAN_DIV(4)
    ) dut (
        .clock     (clk),
        .restart   (rst),
        .rif       (rif.slave),
        .row_sel   (row_sel),
        .col_data  (col_data),
        .db_frames (db_frames)
    );

    assign rif.seg_pos = body_mem[rif.seg_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] pos(input int x, input int y);
        return {3'(x), 3'(y)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        rif.render_step = 1'b1;
        @(negedge clk);
        rif.render_step = 1'b0;
    endtask

    task automatic clear(input logic with_step);
        @(negedge clk);
        rif.render_clr  = 1'b1;
        rif.render_step = with_step;
        @(negedge clk);
        rif.render_clr  = 1'b0;
        rif.render_step = 1'b0;
    endtask

    // Wait (bounded) until row r is being scanned, then check its pixels.
    task automatic check_row(input int r, input logic [7:0] exp);
        logic [7:0] sel;
        int t;
        sel = 8'h01 << r;
        t = 0;
        while (row_sel !== sel && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("row%0d_sync", r), 16'(t < 40), 16'd1);
        chk($sformatf("row%0d_pixels", r), 16'(col_data), 16'(exp));
    endtask

    logic [7:0] exp_front [8];

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        rif.render_clr  = 1'b0;
        rif.render_step = 1'b0;
        rif.snake_size  = '0;
        rif.apple_pos   = '0;
        for (int i = 0; i < 32; i++) body_mem[i] = '0;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_finish", 16'(rif.render_finish), 16'd0);
        chk("rst_seg_addr", 16'(rif.seg_addr), 16'd0);
        chk("rst_frames", 16'(db_frames), 16'd0);
        chk("rst_row_sel", 16'(row_sel), 16'h01);
        chk("rst_col_data", 16'(col_data), 16'h00);
        rst = 1'b0;

        // Normal frame: three segments on row 1, apple at (5,5)
        body_mem[0] = pos(1, 1);
        body_mem[1] = pos(2, 1);
        body_mem[2] = pos(3, 1);
        rif.snake_size = 5'd3;
        rif.apple_pos  = pos(5, 5);
        for (int s = 1; s <= 3; s++) begin
            step();
            chk($sformatf("nf_seg_addr_s%0d", s), 16'(rif.seg_addr), 16'(s));
            chk($sformatf("nf_finish_s%0d", s), 16'(rif.render_finish), 16'd0);
        end
        step();
        chk("nf_finish", 16'(rif.render_finish), 16'd1);
        chk("nf_frames", 16'(db_frames), 16'd1);
        chk("nf_seg_addr_hold", 16'(rif.seg_addr), 16'd3);
        check_row(1, 8'b0000_1110);
        check_row(5, 8'b0010_0000);
        check_row(0, 8'h00);
        step();
        chk("nf_ack_finish", 16'(rif.render_finish), 16'd0);
        chk("nf_ack_seg_addr", 16'(rif.seg_addr), 16'd0);
        chk("nf_ack_frames", 16'(db_frames), 16'd1);

        // Clear mid-frame
        step();
        step();
        chk("cm_seg_addr_pre", 16'(rif.seg_addr), 16'd2);
        clear(1'b0);
        chk("cm_seg_addr", 16'(rif.seg_addr), 16'd0);
        chk("cm_finish", 16'(rif.render_finish), 16'd0);
        chk("cm_frames", 16'(db_frames), 16'd0);
        for (int r = 0; r < 8; r++) check_row(r, 8'h00);
        for (int s = 0; s < 4; s++) step();
        chk("cm_next_finish", 16'(rif.render_finish), 16'd1);
        chk("cm_next_frames", 16'(db_frames), 16'd1);
        check_row(1, 8'b0000_1110);
        check_row(5, 8'b0010_0000);
        step();

        // Clear with a simultaneous step, then a zero-size frame
        step();
        chk("cs_seg_addr_pre", 16'(rif.seg_addr), 16'd1);
        clear(1'b1);
        chk("cs_seg_addr", 16'(rif.seg_addr), 16'd0);
        chk("cs_finish", 16'(rif.render_finish), 16'd0);
        rif.snake_size = 5'd0;
        rif.apple_pos  = pos(0, 7);
        step();
        chk("z_finish", 16'(rif.render_finish), 16'd1);
        chk("z_frames", 16'(db_frames), 16'd1);
        chk("z_seg_addr", 16'(rif.seg_addr), 16'd0);
        check_row(7, 8'b0000_0001);
        check_row(1, 8'h00);
        step();
        chk("z_ack_finish", 16'(rif.render_finish), 16'd0);

        // Oversize: 20 requested, only 16 drawn (rows 0 and 1 filled)
        for (int i = 0; i < 20; i++) body_mem[i] = pos(i % 8, i / 8);
        rif.snake_size = 5'd20;
        rif.apple_pos  = pos(0, 4);
        for (int s = 0; s < 16; s++) step();
        chk("big_seg_addr", 16'(rif.seg_addr), 16'd16);
        chk("big_finish_16", 16'(rif.render_finish), 16'd0);
        step();
        chk("big_finish_17", 16'(rif.render_finish), 16'd1);
        chk("big_frames", 16'(db_frames), 16'd2);
        check_row(0, 8'hFF);
        check_row(1, 8'hFF);
        check_row(2, 8'h00);
        check_row(4, 8'h01);

        // Scan: four clocks per row, full sweep plus wrap
        for (int r = 0; r < 8; r++) exp_front[r] = 8'h00;
        exp_front[0] = 8'hFF;
        exp_front[1] = 8'hFF;
        exp_front[4] = 8'h01;
        begin
            int t;
            t = 0;
            while (row_sel === 8'h01 && t < 40) begin @(negedge clk); t++; end
            while (row_sel !== 8'h01 && t < 80) begin @(negedge clk); t++; end
            chk("scan_sync", 16'(t < 80), 16'd1);
        end
        for (int k = 0; k < 36; k++) begin
            int r;
            r = (k / 4) % 8;
            chk($sformatf("scan_sel_k%0d", k), 16'(row_sel), 16'(8'h01 << r));
            chk($sformatf("scan_col_k%0d", k), 16'(col_data), 16'(exp_front[r]));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sga_render_engine.md
# sga_render_engine

Frame renderer for the Snake Game Arcade, the responder side of the control unit's render handshake. Each step pulse from the control unit draws one snake segment into a back frame buffer. After the last segment it draws the apple, swaps the back buffer into the front buffer, and raises `render_finish`. The front buffer is scanned continuously, one row at a time, onto the LED matrix.

## Interface
- `GRID_W`, 3: coordinate width. Grid is 2^GRID_W × 2^GRID_W (8×8 by default).
- `SIZE_W`, 5: width of the segment index and of `snake_size`.
- `MAX_SIZE`, 16: maximum number of segments drawn.
- `SCAN_DIV`, 1000: clocks per scanned row (≥1).
- `clock`  in  1  system clock; all state changes on its rising edge.
- `restart`  in  1  reset, synchronous, active-high.
- `render_clr`  in  1  clears the frame and the handshake state; the control unit asserts it while idle.
- `render_step`  in  1  one-cycle step pulse; this is the control unit's `count_size`.
- `snake_size`  in  SIZE_W  number of body segments; values above MAX_SIZE are clamped to MAX_SIZE.
- `seg_addr`  out  SIZE_W  read index into the body position memory.
- `seg_pos`  in  2*GRID_W  {x,y} of the segment at `seg_addr`; combinational read, valid in the same cycle.
- `apple_pos`  in  2*GRID_W  {x,y} of the apple.
- `render_finish`  out  1  frame complete; held high until acknowledged.
- `row_sel`  out  2^GRID_W  one-hot row drive.
- `col_data`  out  2^GRID_W  pixels of the selected row; bit x is pixel (x, row).
- `db_frames`  out  8  count of completed frames, wraps at 255 → 0.

## Operation
- Storage: two bitmaps, back and front, each with 2^GRID_W rows of 2^GRID_W bits.
- Registered index `idx` drives `seg_addr` directly.
- Let N = min(`snake_size`, MAX_SIZE). Each `render_step` is handled by the first matching case:
  1. `render_finish`=1 (acknowledge step): clear `render_finish`, set `idx`←0, draw nothing.
  2. `idx` < N: set back[y][x] from `seg_pos`, then `idx`←`idx`+1.
  3. `idx` ≥ N:
     - front ← back with the apple bit OR-ed in;
     - back ← 0;
     - `render_finish` ← 1;
     - `db_frames` ← `db_frames`+1.
- A frame therefore takes N+1 steps; step N+2 is the acknowledge. This matches the control unit's loop:
  - in the RENDERIZA state, the cycle in which it sees `render_finish` high also carries `render_step`;
  - that pulse clears `render_finish`, so the next frame starts clean.
- Duplicate positions (segment on segment, or apple on segment) OR together, so the pixel is simply lit. There is no error.
- N=0: the first step draws only the apple and finishes.
- `render_clr` clears `idx`, `render_finish`, both buffers and `db_frames`. It has priority over a simultaneous `render_step`, and the step is discarded.
- Scan: a divider counts 0..SCAN_DIV-1. On its wrap, `row` increments modulo 2^GRID_W (7 → 0 wraps).
  - `row_sel` = one-hot(`row`).
  - `col_data` = front[`row`], combinational from the registered front buffer and `row`.
  - Scan is unaffected by `render_clr` and by the handshake.
- `restart` has the same effect as `render_clr`, and also resets the divider and `row` to 0.

## Timing
- Reset values:
  - `render_finish`=0, `seg_addr`=0, `db_frames`=0;
  - `row_sel`=0…01, `col_data`=0;
  - all buffer bits 0.
- `seg_addr` changes on the clock edge after a drawing step. `seg_pos` must be stable in the cycle `render_step` is high.
- `render_finish` rises on the edge that samples the final step: step N+1, the apple/swap step.
- The new frame appears on `col_data` in the cycle after that edge.
- Steps may arrive back-to-back or with arbitrary gaps, since the control unit steps every other cycle. Between steps, state holds.
- `render_step` while `render_clr` or `restart` is high has no effect.
- A clear mid-frame abandons the partial frame. The next step begins at `idx`=0.

## Test plan
- **Reset.** Drive `restart`=1 for 2 cycles. Required:
  - `render_finish`=0, `seg_addr`=0, `db_frames`=0;
  - `row_sel`=8'h01, `col_data`=0.
- **Normal frame.** `snake_size`=3, segments (1,1), (2,1), (3,1), apple (5,5), 4 steps. Required:
  - `seg_addr` reads 1, 2, 3 after steps 1–3;
  - `render_finish`=1 after step 4, and `db_frames`=1;
  - front row 1 = 8'b00001110, front row 5 = 8'b00100000.
  - Step 5 then clears `render_finish` and sets `seg_addr`=0.
- **Clear mid-frame.** Two steps, then `render_clr`. Required: `seg_addr`=0, `render_finish`=0, every row of `col_data` reads 0. A following 4-step frame completes normally.
- **Clear with simultaneous step.** `render_clr` and `render_step` in the same cycle. Required: `seg_addr`=0 and no pixel set.
- **Zero size.** `snake_size`=0 with apple (0,7), 1 step. Required: `render_finish`=1 and front row 7 = 8'b00000001. Also, `snake_size`=20 draws exactly 16 segments and finishes on step 17.
- **Scan.** `SCAN_DIV`=4. Required: `row_sel` advances every 4 clocks through 01, 02, …, 80, then wraps to 01, with `col_data` equal to front[`row`] in every cycle.
